// File: rtl/uart_rx_core.sv
// uart_rx_core: UART receive core with mid-bit sampling and a one-entry output register.
//
// The asynchronous rx line passes through a two-flop synchroniser. Frames are received
// LSB first: 8N1 by default, or 8E1 when UART_RX_PARITY_EN is defined. Each good byte is
// offered on a valid/ready holding register. A new byte that arrives while the register
// is still full is dropped, and overrun pulses.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per bit period (must be >= 4)
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   rx          serial input, idle high
//   rx_data     received byte; stable while rx_valid is high
//   rx_valid    holding register full
//   rx_ready    consumer accepts the byte (transfer on rx_valid && rx_ready)
//   busy        receiver is inside a frame (FSM not idle)
//   frame_err   one-cycle pulse: stop bit sampled low
//   overrun     one-cycle pulse: completed byte dropped because the register was full
//   parity_err  one-cycle pulse: even-parity mismatch (constant 0 without UART_RX_PARITY_EN)
// Optional feature macro: UART_RX_PARITY_EN
module uart_rx_core #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfLoad = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullLoad = CntW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e          state_q, state_d;
  logic [1:0]      sync_q;
  logic            rx_s;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tick;
  logic            done, stop_bad;
  logic [7:0]      data_q;
  logic            valid_q, ferr_q, ovr_q;
`ifdef UART_RX_PARITY_EN
  logic            par_q, par_d, par_bad, perr_q;
`endif

  // Synchroniser resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rx};
  end
  assign rx_s = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // cnt_q counts down to the next sample point; tick marks the sampling cycle.
  assign tick = (cnt_q == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    done     = 1'b0;
    stop_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d    = par_q;
    par_bad  = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (!rx_s) begin
          state_d = StStart;
          cnt_d   = HalfLoad;
          bit_d   = '0;
        end
      end
      StStart: begin
        if (tick) begin
          if (rx_s) begin
            state_d = StIdle;  // false start: glitch shorter than half a bit
          end else begin
            state_d = StData;
            cnt_d   = FullLoad;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StData: begin
        if (tick) begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = FullLoad;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (tick) begin
          par_d   = rx_s;
          cnt_d   = FullLoad;
          state_d = StStop;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
`endif
      StStop: begin
        if (tick) begin
          // Leave at mid-stop so a back-to-back frame's start edge is not missed.
          state_d  = StIdle;
          stop_bad = !rx_s;
`ifdef UART_RX_PARITY_EN
          par_bad  = ^{shift_q, par_q};
          done     = rx_s && !par_bad;
`else
          done     = rx_s;
`endif
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Holding register; a pop in the same cycle as completion frees the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ferr_q <= stop_bad;
      ovr_q  <= 1'b0;
      if (done) begin
        if (!valid_q || rx_ready) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) perr_q <= 1'b0;
    else     perr_q <= par_bad;
  end
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign busy      = (state_q != StIdle);
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: self-checking bench for uart_rx_core at CLKS_PER_BIT = 16.
// Stimulus changes 1 ns after the falling clock edge; the monitor samples 2 ns after it.
// Expected bytes go into exp_q when a frame is driven; bytes the DUT hands over
// (rx_valid && rx_ready) go into got_q and are compared in order.
// Define UART_RX_PARITY_EN to build and test the 8E1 variant.
module tb_uart_rx_core;

  localparam int unsigned CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned StopK   = 10;
  localparam int          ExpPerr = 1;
`else
  localparam int unsigned StopK   = 9;
  localparam int          ExpPerr = 0;
`endif
  // Falling edge that drives the start bit = edge 0; the stop bit is sampled on this rising edge.
  localparam int unsigned StopEdge = 3 + CPB / 2 + StopK * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, busy, frame_err, overrun, parity_err;

  uart_rx_core #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int perr_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (frame_err)  ferr_cnt++;
      if (overrun)    ovr_cnt++;
      if (parity_err) perr_cnt++;
    end
  end

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic       accept;
    int         ferr;
  } vec_t;
  vec_t vecs[6];

  task automatic nclk(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit
`ifdef UART_RX_PARITY_EN
                            , input logic flip = 1'b0
`endif
                            );
    rx = 1'b0;
    nclk(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      nclk(CPB);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ flip;
    nclk(CPB);
`endif
    rx = stop_bit;
    nclk(CPB);
    rx = 1'b1;
  endtask

  task automatic drain(input string name);
    logic [7:0] got;
    while (got_q.size() > 0) begin
      got = got_q.pop_front();
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL %s extra byte actual=%02h required=none", name, got);
      end else begin
        check(name, 32'(got), 32'(exp_q.pop_front()));
      end
    end
    check({name, "_missing"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int f0, o0;
    vecs[0] = '{data: 8'hA5, stop_bit: 1'b1, accept: 1'b1, ferr: 0};
    vecs[1] = '{data: 8'h3C, stop_bit: 1'b0, accept: 1'b0, ferr: 1};
    vecs[2] = '{data: 8'h5A, stop_bit: 1'b1, accept: 1'b1, ferr: 0};
    vecs[3] = '{data: 8'h00, stop_bit: 1'b1, accept: 1'b1, ferr: 0};
    vecs[4] = '{data: 8'hFF, stop_bit: 1'b1, accept: 1'b1, ferr: 0};
    vecs[5] = '{data: 8'h81, stop_bit: 1'b0, accept: 1'b0, ferr: 1};

    // Reset state
    nclk(3);
    check("reset_outputs", 32'({rx_data, rx_valid, busy, frame_err, overrun, parity_err}), 32'd0);
    rst = 1'b0;
    nclk(5);

    // Exact timing of a good frame: busy edge, rx_valid edge, one-cycle valid with ready high
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        nclk(2);
        check("busy_before_t0", 32'(busy), 32'd0);
        nclk(1);
        check("busy_at_t0p1", 32'(busy), 32'd1);
        nclk(StopEdge - 4);
        check("valid_early", 32'(rx_valid), 32'd0);
        nclk(1);
        check("valid_after_stop", 32'(rx_valid), 32'd1);
        check("data_after_stop", 32'(rx_data), 32'hA5);
        check("busy_after_stop", 32'(busy), 32'd0);
        nclk(1);
        check("valid_one_cycle", 32'(rx_valid), 32'd0);
      end
    join
    nclk(CPB);
    drain("first_frame");

    // False start: 4 cycles low
    f0 = ferr_cnt;
    rx = 1'b0;
    nclk(4);
    check("false_start_busy", 32'(busy), 32'd1);
    rx = 1'b1;
    nclk(2 * CPB);
    check("false_start_idle", 32'(busy), 32'd0);
    check("false_start_ferr", 32'(ferr_cnt - f0), 32'd0);
    drain("false_start");

    // Table of frames with rx_ready held high
    for (int v = 0; v < 6; v++) begin
      f0 = ferr_cnt;
      o0 = ovr_cnt;
      if (vecs[v].accept) exp_q.push_back(vecs[v].data);
      send_frame(vecs[v].data, vecs[v].stop_bit);
      nclk(2 * CPB);
      check($sformatf("vec%0d_ferr", v), 32'(ferr_cnt - f0), 32'(vecs[v].ferr));
      check($sformatf("vec%0d_ovr", v), 32'(ovr_cnt - o0), 32'd0);
      check($sformatf("vec%0d_busy", v), 32'(busy), 32'd0);
      check($sformatf("vec%0d_valid", v), 32'(rx_valid), 32'd0);
      drain($sformatf("vec%0d_byte", v));
    end

    // Overrun: two back-to-back frames with no consumer
    rx_ready = 1'b0;
    o0 = ovr_cnt;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    nclk(CPB);
    check("ovr_valid_held", 32'(rx_valid), 32'd1);
    check("ovr_data_kept", 32'(rx_data), 32'h11);
    check("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
    check("ovr_no_xfer", 32'(got_q.size()), 32'd0);
    rx_ready = 1'b1;
    nclk(1);
    check("ovr_pop_clears", 32'(rx_valid), 32'd0);
    check("ovr_pop_data_hold", 32'(rx_data), 32'h11);
    drain("ovr_pop");

    // Pop exactly in the completion cycle of 0x33 while 0x11 is held
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    nclk(CPB);
    o0 = ovr_cnt;
    exp_q.push_back(8'h33);
    fork
      send_frame(8'h33, 1'b1);
      begin
        nclk(StopEdge - 1);
        check("coinc_still_old", 32'(rx_data), 32'h11);
        rx_ready = 1'b1;
        nclk(1);
        check("coinc_valid", 32'(rx_valid), 32'd1);
        check("coinc_data", 32'(rx_data), 32'h33);
      end
    join
    nclk(CPB);
    check("coinc_no_ovr", 32'(ovr_cnt - o0), 32'd0);
    drain("coinc_bytes");

    // Reset in the middle of data bit 4, then a clean 0xC3
    rx = 1'b0;
    nclk(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      nclk(CPB);
    end
    rx = 1'b0;
    nclk(CPB / 2);
    rst = 1'b1;
    nclk(1);
    check("midrst_outputs", 32'({rx_data, rx_valid, busy, frame_err, overrun, parity_err}), 32'd0);
    rx = 1'b1;
    nclk(2);
    rst = 1'b0;
    nclk(4);
    f0 = ferr_cnt;
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1);
    nclk(2 * CPB);
    check("midrst_ferr", 32'(ferr_cnt - f0), 32'd0);
    drain("midrst_c3");

`ifdef UART_RX_PARITY_EN
    // Parity: 0x07 needs parity bit 1 for even parity
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b0);
    nclk(2 * CPB);
    drain("par_good");
    send_frame(8'h07, 1'b1, 1'b1);
    nclk(2 * CPB);
    check("par_bad_valid", 32'(rx_valid), 32'd0);
    drain("par_bad");
`endif
    check("perr_total", 32'(perr_cnt), 32'(ExpPerr));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
